// File: rtl/fdcp_bank_init_ctrl.sv
// Load sequencer for a bank of async-clear/async-preset flops: drives per-bit
// PRE/CLR to force a target value, releases, settles, then verifies readback.
module fdcp_bank_init_ctrl #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               HOLD_CYC   = 2,
  parameter int               SETTLE_CYC = 1
) (
  input  logic             c_i,
  input  logic             clr_n_i,
  input  logic             req_i,
  input  logic             use_pat_i,
  input  logic [WIDTH-1:0] pat_i,
  input  logic [WIDTH-1:0] bank_q_i,
  output logic [WIDTH-1:0] bank_pre_o,
  output logic [WIDTH-1:0] bank_clr_o,
  output logic             bank_ce_o,
  output logic             busy_o,
  output logic             ack_o,
  output logic             err_o
);

  localparam int CNT_MAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] tgt_q;
  logic             from_req_q;
  logic [WIDTH-1:0] pre_q;
  logic [WIDTH-1:0] clr_q;
  logic             ce_q;
  logic             busy_q;
  logic             ack_q;
  logic             err_q;

  logic [WIDTH-1:0] tgt_d;
  logic             mismatch;

  assign tgt_d    = use_pat_i ? pat_i : INIT;
  assign mismatch = (bank_q_i != tgt_q);

  // cnt_q counts hold edges including the accept edge; after reset it starts
  // at 0 so the reset-origin sequence gets a full HOLD_CYC after release.
  always_ff @(posedge c_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      tgt_q      <= INIT;
      from_req_q <= 1'b0;
      pre_q      <= INIT;
      clr_q      <= ~INIT;
      ce_q       <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            state_q    <= S_ASSERT;
            cnt_q      <= CW'(1);
            tgt_q      <= tgt_d;
            from_req_q <= 1'b1;
            pre_q      <= tgt_d;
            clr_q      <= ~tgt_d;
            ce_q       <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (cnt_q == CW'(HOLD_CYC)) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            clr_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ce_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= from_req_q;
            from_req_q <= 1'b0;
            if (mismatch) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          pre_q   <= '0;
          clr_q   <= '0;
          ce_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bank_pre_o = pre_q;
  assign bank_clr_o = clr_q;
  assign bank_ce_o  = ce_q;
  assign busy_o     = busy_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fdcp_bank_init_ctrl.sv
// Bench for fdcp_bank_init_ctrl: directed scenarios plus random traffic, checked
// every cycle against a timeline model of each load sequence.
module tb_fdcp_bank_init_ctrl;

  localparam int         W    = 8;
  localparam logic [7:0] INIT = 8'hA5;
  localparam int         H    = 2;
  localparam int         S    = 1;

  logic       c = 1'b0;
  logic       clr_n = 1'b1;
  logic       req = 1'b0;
  logic       use_pat = 1'b0;
  logic [7:0] pat = 8'h00;
  logic [7:0] bank_q;
  logic [7:0] pre;
  logic [7:0] clr_o;
  logic       ce, busy, ack, err;

  logic [7:0] bank_mem = 8'h00;
  logic [7:0] stuck = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt;

  // model state: a sequence is a timeline anchored at its start edge
  int         cyc = 0;
  bit         m_busy;
  int         m_start;
  logic [7:0] m_tgt;
  bit         m_req_org, m_err, m_ack;

  fdcp_bank_init_ctrl #(
    .WIDTH(W), .INIT(INIT), .HOLD_CYC(H), .SETTLE_CYC(S)
  ) dut (
    .c_i(c), .clr_n_i(clr_n), .req_i(req), .use_pat_i(use_pat), .pat_i(pat),
    .bank_q_i(bank_q), .bank_pre_o(pre), .bank_clr_o(clr_o), .bank_ce_o(ce),
    .busy_o(busy), .ack_o(ack), .err_o(err)
  );

  always #5 c = ~c;

  // FDCP bank whose D path simply holds; PRE/CLR act asynchronously
  always @(pre or clr_o) bank_mem = (bank_mem | pre) & ~clr_o;
  assign bank_q = bank_mem | stuck;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b1;
    m_tgt     = INIT;
    m_req_org = 1'b0;
    m_err     = 1'b0;
    m_ack     = 1'b0;
    m_start   = cyc + 1;
  endtask

  task automatic model_edge();
    m_ack = 1'b0;
    if (!clr_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (req) begin
        m_busy    = 1'b1;
        m_start   = cyc;
        m_tgt     = use_pat ? pat : INIT;
        m_req_org = 1'b1;
        m_err     = 1'b0;
      end
    end else if (cyc == m_start + H + S) begin
      m_busy = 1'b0;
      m_ack  = m_req_org;
      if ((m_tgt | stuck) != m_tgt) m_err = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit         drv;
    logic [7:0] e_pre, e_clr;
    drv   = m_busy && (cyc < m_start + H);
    e_pre = drv ? m_tgt : 8'h00;
    e_clr = drv ? ~m_tgt : 8'h00;
    check_val("pre", pre, e_pre);
    check_val("clr", clr_o, e_clr);
    check_val("ce", ce, !m_busy);
    check_val("busy", busy, m_busy);
    check_val("ack", ack, m_ack);
    check_val("err", err, m_err);
    check_val("pre_and_clr", pre & clr_o, 8'h00);
  endtask

  task automatic cycle();
    @(posedge c);
    #1;
    cyc++;
    model_edge();
    check_outputs();
    if (ack) ack_cnt++;
  endtask

  task automatic rst_pulse(input int n);
    #3;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (n) cycle();
    clr_n = 1'b1;
  endtask

  task automatic load(input bit up, input logic [7:0] p);
    req = 1'b1;
    use_pat = up;
    pat = p;
    cycle();
    req = 1'b0;
  endtask

  initial begin
    #1 clr_n = 1'b0;
    #1 model_reset();
    check_outputs();
    repeat (2) cycle();
    clr_n = 1'b1;
    repeat (6) cycle();
    check_val("rst_bank", bank_q, INIT);

    load(1'b1, 8'h3C);
    repeat (4) cycle();
    check_val("pat_bank", bank_q, 8'h3C);

    stuck = 8'h01;
    load(1'b1, 8'h3C);
    repeat (6) cycle();
    check_val("err_sticky", err, 1'b1);
    load(1'b0, 8'h00);
    repeat (4) cycle();
    check_val("init_bank", bank_q, INIT);
    stuck = 8'h00;

    load(1'b1, 8'h3C);
    ack_cnt = 0;
    load(1'b1, 8'hFF);
    repeat (5) cycle();
    check_val("busy_req_acks", ack_cnt, 1);
    check_val("busy_req_bank", bank_q, 8'h3C);

    load(1'b1, 8'h0F);
    repeat (2) cycle();
    rst_pulse(1);
    repeat (6) cycle();
    check_val("midrst_bank", bank_q, INIT);

    ack_cnt = 0;
    req = 1'b1;
    use_pat = 1'b1;
    for (int i = 0; i < 24; i++) begin
      pat = (i % 2 == 1) ? 8'hF0 : 8'h0F;
      cycle();
    end
    req = 1'b0;
    check_val("b2b_acks", ack_cnt, 6);
    repeat (4) cycle();

    for (int i = 0; i < 800; i++) begin
      req = ($urandom % 3 == 0);
      use_pat = 1'($urandom % 2);
      pat = 8'($urandom);
      if ($urandom % 25 == 0) stuck = ($urandom % 2 == 1) ? (8'h01 << ($urandom % 8)) : 8'h00;
      if ($urandom % 200 == 0) rst_pulse(int'($urandom % 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
